// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared definitions for the register-transfer sequencer: op codes, FSM state
// encodings and small op-classification helpers.
package reg_xfer_ctrl_pkg;

    localparam logic [1:0] XOP_MOV       = 2'd0;
    localparam logic [1:0] XOP_ALU       = 2'd1;
    localparam logic [1:0] XOP_LOAD_EXT  = 2'd2;
    localparam logic [1:0] XOP_STORE_EXT = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    function automatic logic op_uses_main(input logic [1:0] op);
        return (op == XOP_MOV) || (op == XOP_STORE_EXT);
    endfunction

    function automatic logic op_loads_reg(input logic [1:0] op);
        return (op != XOP_STORE_EXT);
    endfunction

endpackage

// File: rtl/xfer_dec_bar.sv
// Active-low one-hot decoder with active-low enable; all outputs high when
// disabled.
module xfer_dec_bar
    import reg_xfer_ctrl_pkg::*;
#(
    parameter  int REG_W = 2,
    localparam int NREGS = 2 ** REG_W
) (
    input  logic [REG_W-1:0] idx_i,
    input  logic             en_bar_i,
    output logic [NREGS-1:0] dec_bar_o
);

    // Decode the index into a single low bit when enabled
    always_comb begin
        dec_bar_o = '1;
        for (int i = 0; i < NREGS; i++) begin
            if (!en_bar_i && (int'(idx_i) == i)) begin
                dec_bar_o[i] = 1'b0;
            end else begin
                dec_bar_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Transfer sequencer in front of the general-purpose register file: drives the
// per-register bus/load strobes with settle time before load and dead time after.
module reg_xfer_ctrl
    import reg_xfer_ctrl_pkg::*;
#(
    parameter  int REG_W         = 2,
    parameter  int SETTLE_CYCLES = 1,
    localparam int NREGS         = 2 ** REG_W
) (
    input  logic             CLK,
    input  logic             RST_bar,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [REG_W-1:0] REQ_SRC,
    input  logic [REG_W-1:0] REQ_SRC2,
    input  logic [REG_W-1:0] REQ_DST,
    output logic [NREGS-1:0] ASSERT_MAIN_bar,
    output logic [NREGS-1:0] ASSERT_LHS_bar,
    output logic [NREGS-1:0] ASSERT_RHS_bar,
    output logic [NREGS-1:0] LOAD_bar,
    output logic             ALU_ASSERT_bar,
    output logic             EXT_ASSERT_bar,
    output logic             EXT_LOAD_bar,
    output logic             BUSY,
    output logic [15:0]      XFER_COUNT
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    logic [1:0]       state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [1:0]       op_q, op_d;
    logic [REG_W-1:0] src_q, src_d, src2_q, src2_d, dst_q, dst_d;
    logic [15:0]      xfer_count_q, xfer_count_d;
    logic             ready_q, busy_q, alu_bar_q, ext_a_bar_q, ext_l_bar_q;
    logic [NREGS-1:0] main_bar_q, lhs_bar_q, rhs_bar_q, load_bar_q;
    logic [NREGS-1:0] main_bar_s, lhs_bar_s, rhs_bar_s, load_bar_s;
    logic             accept_s, drive_s, loading_s;

    // Next state, latched request fields and transfer counter
    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        op_d         = op_q;
        src_d        = src_q;
        src2_d       = src2_q;
        dst_d        = dst_q;
        xfer_count_d = xfer_count_q;
        accept_s     = REQ_VALID && ready_q && (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d  = ST_DRIVE;
                    settle_d = SETTLE_INIT;
                    op_d     = REQ_OP;
                    src_d    = REQ_SRC;
                    src2_d   = REQ_SRC2;
                    dst_d    = REQ_DST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (settle_q <= 4'd1) begin
                    state_d = ST_LOAD;
                end else begin
                    settle_d = settle_q - 4'd1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_LOAD: begin
                state_d      = ST_GAP;
                xfer_count_d = xfer_count_q + 16'd1;
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so the registered outputs line up with it
    always_comb begin
        drive_s   = (state_d == ST_DRIVE) || (state_d == ST_LOAD);
        loading_s = (state_d == ST_LOAD);
    end

    xfer_dec_bar #(.REG_W(REG_W)) u_dec_main (
        .idx_i(src_d), .en_bar_i(!(drive_s && op_uses_main(op_d))), .dec_bar_o(main_bar_s));
    xfer_dec_bar #(.REG_W(REG_W)) u_dec_lhs (
        .idx_i(src_d), .en_bar_i(!(drive_s && (op_d == XOP_ALU))), .dec_bar_o(lhs_bar_s));
    xfer_dec_bar #(.REG_W(REG_W)) u_dec_rhs (
        .idx_i(src2_d), .en_bar_i(!(drive_s && (op_d == XOP_ALU))), .dec_bar_o(rhs_bar_s));
    xfer_dec_bar #(.REG_W(REG_W)) u_dec_load (
        .idx_i(dst_d), .en_bar_i(!(loading_s && op_loads_reg(op_d))), .dec_bar_o(load_bar_s));

    // State and output registers; reset forces every strobe inactive at once
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q      <= ST_IDLE;
            settle_q     <= 4'd0;
            op_q         <= 2'd0;
            src_q        <= '0;
            src2_q       <= '0;
            dst_q        <= '0;
            xfer_count_q <= 16'd0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            main_bar_q   <= '1;
            lhs_bar_q    <= '1;
            rhs_bar_q    <= '1;
            load_bar_q   <= '1;
            alu_bar_q    <= 1'b1;
            ext_a_bar_q  <= 1'b1;
            ext_l_bar_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            op_q         <= op_d;
            src_q        <= src_d;
            src2_q       <= src2_d;
            dst_q        <= dst_d;
            xfer_count_q <= xfer_count_d;
            ready_q      <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            main_bar_q   <= main_bar_s;
            lhs_bar_q    <= lhs_bar_s;
            rhs_bar_q    <= rhs_bar_s;
            load_bar_q   <= load_bar_s;
            alu_bar_q    <= !(drive_s && (op_d == XOP_ALU));
            ext_a_bar_q  <= !(drive_s && (op_d == XOP_LOAD_EXT));
            ext_l_bar_q  <= !(loading_s && (op_d == XOP_STORE_EXT));
        end
    end

    assign REQ_READY       = ready_q;
    assign BUSY            = busy_q;
    assign XFER_COUNT      = xfer_count_q;
    assign ASSERT_MAIN_bar = main_bar_q;
    assign ASSERT_LHS_bar  = lhs_bar_q;
    assign ASSERT_RHS_bar  = rhs_bar_q;
    assign LOAD_bar        = load_bar_q;
    assign ALU_ASSERT_bar  = alu_bar_q;
    assign EXT_ASSERT_bar  = ext_a_bar_q;
    assign EXT_LOAD_bar    = ext_l_bar_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: two builds (settle 1 and 3) share stimulus and are
// compared every cycle against a cycle-count model, plus directed literal checks.
module tb_reg_xfer_ctrl;

    logic       CLK = 1'b0;
    logic       RST_bar;
    logic       REQ_VALID;
    logic [1:0] REQ_OP, REQ_SRC, REQ_SRC2, REQ_DST;

    logic       ready_o [2];
    logic       busy_o  [2];
    logic       alu_o   [2];
    logic       exta_o  [2];
    logic       extl_o  [2];
    logic [3:0] main_o  [2];
    logic [3:0] lhs_o   [2];
    logic [3:0] rhs_o   [2];
    logic [3:0] load_o  [2];
    logic [15:0] cnt_o  [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic cmp_en   = 1'b0;
    logic wrap_req = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    reg_xfer_ctrl #(.REG_W(2), .SETTLE_CYCLES(1)) dut1 (
        .CLK(CLK), .RST_bar(RST_bar), .REQ_VALID(REQ_VALID), .REQ_READY(ready_o[0]),
        .REQ_OP(REQ_OP), .REQ_SRC(REQ_SRC), .REQ_SRC2(REQ_SRC2), .REQ_DST(REQ_DST),
        .ASSERT_MAIN_bar(main_o[0]), .ASSERT_LHS_bar(lhs_o[0]), .ASSERT_RHS_bar(rhs_o[0]),
        .LOAD_bar(load_o[0]), .ALU_ASSERT_bar(alu_o[0]), .EXT_ASSERT_bar(exta_o[0]),
        .EXT_LOAD_bar(extl_o[0]), .BUSY(busy_o[0]), .XFER_COUNT(cnt_o[0]));

    reg_xfer_ctrl #(.REG_W(2), .SETTLE_CYCLES(3)) dut3 (
        .CLK(CLK), .RST_bar(RST_bar), .REQ_VALID(REQ_VALID), .REQ_READY(ready_o[1]),
        .REQ_OP(REQ_OP), .REQ_SRC(REQ_SRC), .REQ_SRC2(REQ_SRC2), .REQ_DST(REQ_DST),
        .ASSERT_MAIN_bar(main_o[1]), .ASSERT_LHS_bar(lhs_o[1]), .ASSERT_RHS_bar(rhs_o[1]),
        .LOAD_bar(load_o[1]), .ALU_ASSERT_bar(alu_o[1]), .EXT_ASSERT_bar(exta_o[1]),
        .EXT_LOAD_bar(extl_o[1]), .BUSY(busy_o[1]), .XFER_COUNT(cnt_o[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Model: k = cycles elapsed since the accepting edge (0 = idle)
    int         mk    [2];
    logic       m_rdy [2];
    logic [1:0] m_op  [2], m_src [2], m_src2 [2], m_dst [2];
    logic [15:0] m_cnt [2];

    // Reference model advance
    always @(posedge CLK or negedge RST_bar) begin : model
        int nk;
        for (int i = 0; i < 2; i++) begin
            if (!RST_bar) begin
                mk[i]    <= 0;
                m_rdy[i] <= 1'b0;
                m_cnt[i] <= 16'd0;
            end else begin
                nk = mk[i];
                if (mk[i] == 0) begin
                    if (m_rdy[i] && REQ_VALID) begin
                        nk        = 1;
                        m_op[i]   <= REQ_OP;
                        m_src[i]  <= REQ_SRC;
                        m_src2[i] <= REQ_SRC2;
                        m_dst[i]  <= REQ_DST;
                    end
                end else if (mk[i] == settle_of(i) + 2) begin
                    nk = 0;
                end else begin
                    nk = mk[i] + 1;
                end
                mk[i]    <= nk;
                m_rdy[i] <= (nk == 0);
                if (i == 0 && wrap_req) m_cnt[i] <= 16'hFFFF;
                else if (nk == settle_of(i) + 2) m_cnt[i] <= m_cnt[i] + 16'd1;
            end
        end
    end

    // Per-cycle comparison of both builds against the model
    always @(negedge CLK) begin : compare
        logic [3:0] e_main, e_lhs, e_rhs, e_load;
        logic e_alu, e_exta, e_extl, drv, ld, any_assert;
        int lows_bus, lows_ld;
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                drv = (mk[i] >= 1) && (mk[i] <= settle_of(i) + 1);
                ld  = (mk[i] == settle_of(i) + 1);
                e_main = 4'hF; e_lhs = 4'hF; e_rhs = 4'hF; e_load = 4'hF;
                e_alu = 1'b1; e_exta = 1'b1; e_extl = 1'b1;
                if (drv) begin
                    case (m_op[i])
                        2'd0: e_main[m_src[i]] = 1'b0;
                        2'd1: begin e_lhs[m_src[i]] = 1'b0; e_rhs[m_src2[i]] = 1'b0; e_alu = 1'b0; end
                        2'd2: e_exta = 1'b0;
                        default: e_main[m_src[i]] = 1'b0;
                    endcase
                end
                if (ld) begin
                    if (m_op[i] == 2'd3) e_extl = 1'b0;
                    else e_load[m_dst[i]] = 1'b0;
                end
                chk($sformatf("ready%0d", i), ready_o[i], m_rdy[i]);
                chk($sformatf("busy%0d", i),  busy_o[i],  mk[i] != 0);
                chk($sformatf("main%0d", i),  main_o[i],  e_main);
                chk($sformatf("lhs%0d", i),   lhs_o[i],   e_lhs);
                chk($sformatf("rhs%0d", i),   rhs_o[i],   e_rhs);
                chk($sformatf("load%0d", i),  load_o[i],  e_load);
                chk($sformatf("alu%0d", i),   alu_o[i],   e_alu);
                chk($sformatf("exta%0d", i),  exta_o[i],  e_exta);
                chk($sformatf("extl%0d", i),  extl_o[i],  e_extl);
                chk($sformatf("count%0d", i), cnt_o[i],   m_cnt[i]);
                lows_bus   = $countones(~main_o[i]) + (alu_o[i] ? 0 : 1) + (exta_o[i] ? 0 : 1);
                lows_ld    = $countones(~load_o[i]) + (extl_o[i] ? 0 : 1);
                any_assert = (lows_bus != 0) || (lhs_o[i] != 4'hF);
                chk($sformatf("excl_bus%0d", i), (lows_bus <= 1) && ($countones(~lhs_o[i]) <= 1)
                    && ($countones(~rhs_o[i]) <= 1), 1);
                chk($sformatf("excl_load%0d", i), (lows_ld <= 1) && (lows_ld == 0 || any_assert), 1);
            end
        end
    end

    task automatic req(input logic [1:0] op, input logic [1:0] s, input logic [1:0] s2,
                       input logic [1:0] d);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_SRC = s; REQ_SRC2 = s2; REQ_DST = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, last;
        REQ_VALID = 1'b0; REQ_OP = 2'd0; REQ_SRC = 2'd0; REQ_SRC2 = 2'd0; REQ_DST = 2'd0;
        RST_bar = 1'b1;
        #1 RST_bar = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_ready", ready_o[0], 1'b0);
        chk("rst_main", main_o[0], 4'hF);
        chk("rst_count", cnt_o[0], 16'h0000);
        RST_bar = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", ready_o[0], 1'b1);

        // MOV src=1 dst=2
        req(2'd0, 2'd1, 2'd0, 2'd2);
        @(negedge CLK); REQ_VALID = 1'b0;
        chk("mov_c1_main", main_o[0], 4'b1101);
        chk("mov_c1_load", load_o[0], 4'b1111);
        @(negedge CLK);
        chk("mov_c2_main", main_o[0], 4'b1101);
        chk("mov_c2_load", load_o[0], 4'b1011);
        @(negedge CLK);
        chk("mov_c3_main", main_o[0], 4'b1111);
        chk("mov_c3_load", load_o[0], 4'b1111);
        chk("mov_c3_count", cnt_o[0], 16'd1);
        @(negedge CLK);
        chk("mov_c4_ready", ready_o[0], 1'b1);
        repeat (4) @(negedge CLK);

        // ALU src=0 src2=3 dst=0
        req(2'd1, 2'd0, 2'd3, 2'd0);
        @(negedge CLK); REQ_VALID = 1'b0;
        chk("alu_lhs", lhs_o[0], 4'b1110);
        chk("alu_rhs", rhs_o[0], 4'b0111);
        chk("alu_strobe", alu_o[0], 1'b0);
        chk("alu_main", main_o[0], 4'b1111);
        @(negedge CLK);
        chk("alu_load", load_o[0], 4'b1110);
        repeat (6) @(negedge CLK);

        // LOAD_EXT dst=3 on the settle-3 build
        req(2'd2, 2'd0, 2'd0, 2'd3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK); REQ_VALID = 1'b0;
            chk($sformatf("lext_exta_c%0d", c), exta_o[1], (c <= 4) ? 1'b0 : 1'b1);
            chk($sformatf("lext_load_c%0d", c), load_o[1], (c == 4) ? 4'b0111 : 4'b1111);
        end
        repeat (4) @(negedge CLK);

        // VALID held with changing fields: one accept per 4 cycles on settle-1 build
        acc = 0; last = -1;
        for (int t = 0; t < 100 && acc < 10; t++) begin
            req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)));
            @(negedge CLK);
            if (ready_o[0]) begin
                if (last >= 0) chk("period", cyc - last, 4);
                last = cyc;
                acc++;
            end
        end
        chk("held_accepts", acc, 10);

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)));
            REQ_VALID = ($urandom_range(0, 1) == 1);
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        repeat (8) @(negedge CLK);

        // Reset during LOAD of STORE_EXT src=2
        req(2'd3, 2'd2, 2'd0, 2'd1);
        @(negedge CLK); REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("store_extl", extl_o[0], 1'b0);
        chk("store_main", main_o[0], 4'b1011);
        #2 RST_bar = 1'b0;
        #1;
        chk("arst_extl", extl_o[0], 1'b1);
        chk("arst_main", main_o[0], 4'b1111);
        chk("arst_count", cnt_o[0], 16'd0);
        @(negedge CLK);
        RST_bar = 1'b1;
        @(negedge CLK);
        chk("arst_ready", ready_o[0], 1'b1);
        repeat (2) @(negedge CLK);

        // Counter wrap
        #1 force dut1.xfer_count_q = 16'hFFFF;
        wrap_req = 1'b1;
        @(posedge CLK);
        #1 release dut1.xfer_count_q;
        wrap_req = 1'b0;
        @(negedge CLK);
        chk("wrap_pre", cnt_o[0], 16'hFFFF);
        req(2'd0, 2'd3, 2'd0, 2'd3);
        @(negedge CLK); REQ_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("wrap_post", cnt_o[0], 16'h0000);
        repeat (6) @(negedge CLK);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
